// File: rtl/arcade_input_pkg.sv
// Shared constants, scancodes and the rotation helper for the arcade input front end.
package arcade_input_pkg;

  localparam int BIT_R     = 0;
  localparam int BIT_L     = 1;
  localparam int BIT_D     = 2;
  localparam int BIT_U     = 3;
  localparam int BIT_FIRE1 = 4;
  localparam int BIT_FIRE2 = 5;
  localparam int BIT_START = 6;

  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_P1_F1_A  = 8'h29;
  localparam logic [7:0] SC_P1_F1_B  = 8'h14;
  localparam logic [7:0] SC_P1_F2    = 8'h11;
  localparam logic [7:0] SC_P1_ST_A  = 8'h16;
  localparam logic [7:0] SC_P1_ST_B  = 8'h05;
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_F1    = 8'h1C;
  localparam logic [7:0] SC_P2_F2    = 8'h1B;
  localparam logic [7:0] SC_P2_ST_A  = 8'h1E;
  localparam logic [7:0] SC_P2_ST_B  = 8'h06;
  localparam logic [7:0] SC_COIN0    = 8'h2E;
  localparam logic [7:0] SC_COIN1    = 8'h36;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_CCW  = 2'd2,
    ROT_180  = 2'd3
  } rot_mode_e;

  // dir is {U,D,L,R}; each output direction takes the listed source direction.
  function automatic logic [3:0] rotate(input logic [3:0] dir, input rot_mode_e mode);
    case (mode)
      ROT_NONE: rotate = dir;
      ROT_CW:   rotate = {dir[BIT_L], dir[BIT_R], dir[BIT_D], dir[BIT_U]};
      ROT_CCW:  rotate = {dir[BIT_R], dir[BIT_L], dir[BIT_U], dir[BIT_D]};
      ROT_180:  rotate = {dir[BIT_D], dir[BIT_U], dir[BIT_R], dir[BIT_L]};
      default:  rotate = dir;
    endcase
  endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// Rising-edge triggered, non-retriggerable pulse of exactly LEN cycles.
module input_pulse_stretch #(
  parameter int LEN = 400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic trig_in,
  output logic pulse_out
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [CW-1:0] cnt_r;
  logic          prev_r;

  // Edge detect always tracks the trigger so a held source cannot re-fire after the pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_r    <= 1'b0;
      cnt_r     <= '0;
      pulse_out <= 1'b0;
    end else begin
      prev_r <= trig_in;
      if (pulse_out) begin
        if (cnt_r == '0) begin
          pulse_out <= 1'b0;
        end else begin
          cnt_r <= cnt_r - 1'b1;
        end
      end else if (trig_in && !prev_r) begin
        pulse_out <= 1'b1;
        cnt_r     <= CW'(LEN - 1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick merge, rotation and coin stretching for arcade cores.
// Optional autofire on fire1 is built when ARCADE_AUTOFIRE_EN is defined.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int N_PLAYERS      = 2,
  parameter int N_COINS        = 2,
  parameter int COIN_PULSE_CYC = 400000,
  parameter int COIN_ON_START  = 1,
  parameter int AUTOFIRE_HALF  = 2000000
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [10:0]             ps2_key,
  input  logic [16*N_PLAYERS-1:0] joy_in,
  input  logic                    merge_joy,
  input  logic [1:0]              rot_mode,
  input  logic                    kbd_clear,
`ifdef ARCADE_AUTOFIRE_EN
  input  logic [N_PLAYERS-1:0]    autofire,
`endif
  output logic [8*N_PLAYERS-1:0]  ctl_out,
  output logic [N_COINS-1:0]      coin_out,
  output logic                    key_event
);

  localparam int COIN1_IDX = (N_COINS > 1) ? 1 : 0;

  logic             armed_r, old_toggle_r, event_s;
  logic [1:0][6:0]  kbd_r, kbd_nxt_s;
  logic [1:0]       coin_key_r, coin_nxt_s;
  logic [15:0]      joy_or_s;
  logic [6:0]       raw_s [N_PLAYERS];
  logic [N_PLAYERS-1:0] fire1_s;
  logic [8*N_PLAYERS-1:0] ctl_nxt_s;
  logic [N_COINS-1:0] trig_s;
  logic             unused_s;

  // The first cycle after reset only arms the toggle tracker so a pre-set toggle is not an event.
  assign event_s  = armed_r && (ps2_key[10] != old_toggle_r);
  assign unused_s = ^joy_or_s[15:7];

  // Scancode decode into held key states; clear overrides any coincident event.
  always_comb begin
    kbd_nxt_s  = kbd_r;
    coin_nxt_s = coin_key_r;
    if (kbd_clear) begin
      kbd_nxt_s  = '0;
      coin_nxt_s = 2'b00;
    end else if (event_s) begin
      case (ps2_key[7:0])
        SC_UP:                    kbd_nxt_s[0][BIT_U]     = ps2_key[9];
        SC_DOWN:                  kbd_nxt_s[0][BIT_D]     = ps2_key[9];
        SC_LEFT:                  kbd_nxt_s[0][BIT_L]     = ps2_key[9];
        SC_RIGHT:                 kbd_nxt_s[0][BIT_R]     = ps2_key[9];
        SC_P1_F1_A, SC_P1_F1_B:   kbd_nxt_s[0][BIT_FIRE1] = ps2_key[9];
        SC_P1_F2:                 kbd_nxt_s[0][BIT_FIRE2] = ps2_key[9];
        SC_P1_ST_A, SC_P1_ST_B:   kbd_nxt_s[0][BIT_START] = ps2_key[9];
        SC_P2_UP:                 kbd_nxt_s[1][BIT_U]     = ps2_key[9];
        SC_P2_DOWN:               kbd_nxt_s[1][BIT_D]     = ps2_key[9];
        SC_P2_LEFT:               kbd_nxt_s[1][BIT_L]     = ps2_key[9];
        SC_P2_RIGHT:              kbd_nxt_s[1][BIT_R]     = ps2_key[9];
        SC_P2_F1:                 kbd_nxt_s[1][BIT_FIRE1] = ps2_key[9];
        SC_P2_F2:                 kbd_nxt_s[1][BIT_FIRE2] = ps2_key[9];
        SC_P2_ST_A, SC_P2_ST_B:   kbd_nxt_s[1][BIT_START] = ps2_key[9];
        SC_COIN0:                 coin_nxt_s[0]           = ps2_key[9];
        SC_COIN1:                 coin_nxt_s[COIN1_IDX]   = ps2_key[9];
        default:                  kbd_nxt_s               = kbd_r;
      endcase
    end else begin
      kbd_nxt_s  = kbd_r;
      coin_nxt_s = coin_key_r;
    end
  end

  // Keyboard event tracking and held key state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_r      <= 1'b0;
      old_toggle_r <= 1'b0;
      key_event    <= 1'b0;
      kbd_r        <= '0;
      coin_key_r   <= 2'b00;
    end else begin
      armed_r      <= 1'b1;
      old_toggle_r <= ps2_key[10];
      key_event    <= event_s;
      kbd_r        <= kbd_nxt_s;
      coin_key_r   <= coin_nxt_s;
    end
  end

  // Merge keyboard and joystick per player; only players 1-2 have keyboard keys.
  always_comb begin
    joy_or_s = 16'h0000;
    for (int p = 0; p < N_PLAYERS; p++) begin
      joy_or_s = joy_or_s | joy_in[16*p +: 16];
    end
    for (int p = 0; p < N_PLAYERS; p++) begin
      raw_s[p] = merge_joy ? joy_or_s[6:0] : joy_in[16*p +: 7];
      if (p < 2) begin
        raw_s[p] = raw_s[p] | kbd_r[1'(p)];
      end else begin
        raw_s[p] = raw_s[p];
      end
    end
  end

`ifdef ARCADE_AUTOFIRE_EN
  localparam int AFW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

  logic [AFW-1:0]       af_cnt_r [N_PLAYERS];
  logic [AFW-1:0]       af_cnt_nxt_s [N_PLAYERS];
  logic [N_PLAYERS-1:0] af_r, af_nxt_s, af_prev_r;

  // Autofire phase: high from the first cycle of a press, toggling every AUTOFIRE_HALF cycles.
  always_comb begin
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (!raw_s[p][BIT_FIRE1]) begin
        af_nxt_s[p]     = 1'b0;
        af_cnt_nxt_s[p] = '0;
      end else if (!af_prev_r[p]) begin
        af_nxt_s[p]     = 1'b1;
        af_cnt_nxt_s[p] = '0;
      end else if (af_cnt_r[p] == AFW'(AUTOFIRE_HALF - 1)) begin
        af_nxt_s[p]     = ~af_r[p];
        af_cnt_nxt_s[p] = '0;
      end else begin
        af_nxt_s[p]     = af_r[p];
        af_cnt_nxt_s[p] = af_cnt_r[p] + 1'b1;
      end
      fire1_s[p] = autofire[p] ? af_nxt_s[p] : raw_s[p][BIT_FIRE1];
    end
  end

  // Autofire counters and press tracking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_r      <= '0;
      af_prev_r <= '0;
      for (int p = 0; p < N_PLAYERS; p++) af_cnt_r[p] <= '0;
    end else begin
      af_r <= af_nxt_s;
      for (int p = 0; p < N_PLAYERS; p++) begin
        af_prev_r[p] <= raw_s[p][BIT_FIRE1];
        af_cnt_r[p]  <= af_cnt_nxt_s[p];
      end
    end
  end
`else
  logic unused_af_s;
  assign unused_af_s = AUTOFIRE_HALF[0];

  // Fire1 passes straight through.
  always_comb begin
    for (int p = 0; p < N_PLAYERS; p++) fire1_s[p] = raw_s[p][BIT_FIRE1];
  end
`endif

  // Output byte assembly: rotate directions, keep buttons, bit 7 tied low.
  always_comb begin
    ctl_nxt_s = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      ctl_nxt_s[8*p +: 8] = {1'b0, raw_s[p][BIT_START], raw_s[p][BIT_FIRE2], fire1_s[p],
                             rotate(raw_s[p][3:0], rot_mode_e'(rot_mode))};
    end
  end

  // Registered control bytes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ctl_out <= '0;
    end else begin
      ctl_out <= ctl_nxt_s;
    end
  end

  // Coin sources: coin keys, plus each start on coin min(p, N_COINS-1).
  always_comb begin
    trig_s = '0;
    for (int c = 0; c < N_COINS; c++) begin
      trig_s[c] = coin_key_r[1'(c)];
      for (int p = 0; p < N_PLAYERS; p++) begin
        if ((COIN_ON_START != 0) && (((p < N_COINS - 1) ? p : N_COINS - 1) == c)) begin
          trig_s[c] = trig_s[c] | raw_s[p][BIT_START];
        end else begin
          trig_s[c] = trig_s[c];
        end
      end
    end
  end

  for (genvar c = 0; c < N_COINS; c++) begin : g_coin
    input_pulse_stretch #(.LEN(COIN_PULSE_CYC)) u_stretch (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .trig_in   (trig_s[c]),
      .pulse_out (coin_out[c])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed self-checking bench for arcade_input_mapper (2 players, 2 coins, short pulses).
module tb_arcade_input_mapper;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        merge_joy;
  logic [1:0]  rot_mode;
  logic        kbd_clear;
`ifdef ARCADE_AUTOFIRE_EN
  logic [1:0]  autofire;
`endif
  logic [15:0] ctl_out;
  logic [1:0]  coin_out;
  logic        key_event;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .N_PLAYERS(2), .N_COINS(2), .COIN_PULSE_CYC(5), .COIN_ON_START(1), .AUTOFIRE_HALF(3)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joy_in    (joy_in),
    .merge_joy (merge_joy),
    .rot_mode  (rot_mode),
    .kbd_clear (kbd_clear),
`ifdef ARCADE_AUTOFIRE_EN
    .autofire  (autofire),
`endif
    .ctl_out   (ctl_out),
    .coin_out  (coin_out),
    .key_event (key_event)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  // Observe one coin bit for n cycles, returning high-cycle and rising-edge counts.
  task automatic watch_coin(input int idx, input int n, output int high, output int rises);
    logic prev;
    high  = 0;
    rises = 0;
    prev  = coin_out[idx];
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (coin_out[idx]) high++;
      if (coin_out[idx] && !prev) rises++;
      prev = coin_out[idx];
    end
  endtask

  initial begin
    int hi, ri, hi_other, ri_other;
    logic [11:0] pat;

    ps2_key   = 11'h400;
    joy_in    = 32'h0;
    merge_joy = 1'b0;
    rot_mode  = 2'd0;
    kbd_clear = 1'b0;
`ifdef ARCADE_AUTOFIRE_EN
    autofire  = 2'b00;
`endif

    tick(3);
    check("reset_ctl", {16'h0, ctl_out}, 32'h0);
    check("reset_coin", {30'h0, coin_out}, 32'h0);
    check("reset_event", {31'h0, key_event}, 32'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("release_quiet", {15'h0, key_event, ctl_out}, 32'h0);
    end

    // Extended up arrow: strobe after one edge, ctl after two.
    send_key(1'b1, 1'b1, 8'h75);
    tick(1);
    check("up_event", {31'h0, key_event}, 32'h1);
    check("up_ctl_lat1", {16'h0, ctl_out}, 32'h0);
    tick(1);
    check("up_event_once", {31'h0, key_event}, 32'h0);
    check("up_ctl_lat2", {16'h0, ctl_out}, 32'h0008);
    send_key(1'b0, 1'b1, 8'h75);
    tick(2);
    check("up_release", {16'h0, ctl_out}, 32'h0);

    send_key(1'b1, 1'b0, 8'h99);
    tick(1);
    check("unmapped_event", {31'h0, key_event}, 32'h1);
    tick(1);
    check("unmapped_ctl", {16'h0, ctl_out}, 32'h0);

    // Left arrow without the extended flag still maps.
    send_key(1'b1, 1'b0, 8'h6B);
    tick(2);
    check("left_noext", {16'h0, ctl_out}, 32'h0002);
    send_key(1'b0, 1'b0, 8'h6B);
    tick(2);
    check("left_release", {16'h0, ctl_out}, 32'h0);

    joy_in   = 32'h0000_0002;
    rot_mode = 2'd1;
    tick(1);
    check("rot_cw_left", {16'h0, ctl_out}, 32'h0008);
    rot_mode = 2'd2;
    tick(1);
    check("rot_ccw_left", {16'h0, ctl_out}, 32'h0004);
    rot_mode = 2'd3;
    tick(1);
    check("rot_180_left", {16'h0, ctl_out}, 32'h0001);
    rot_mode = 2'd0;
    tick(1);
    check("rot_none_left", {16'h0, ctl_out}, 32'h0002);
    joy_in   = 32'h0000_0008;
    rot_mode = 2'd1;
    tick(1);
    check("rot_cw_up", {16'h0, ctl_out}, 32'h0001);
    joy_in   = 32'h0000_000C;
    rot_mode = 2'd0;
    tick(1);
    check("opposing_pass", {16'h0, ctl_out}, 32'h000C);

    joy_in    = 32'h0010_0000;
    merge_joy = 1'b1;
    tick(1);
    check("merge_on", {16'h0, ctl_out}, 32'h1010);
    merge_joy = 1'b0;
    tick(1);
    check("merge_off", {16'h0, ctl_out}, 32'h1000);
    joy_in = 32'h0;
    tick(1);

    send_key(1'b1, 1'b0, 8'h2D);
    tick(2);
    check("p2_up_key", {16'h0, ctl_out}, 32'h0800);
    send_key(1'b0, 1'b0, 8'h2D);
    tick(2);
    check("p2_up_release", {16'h0, ctl_out}, 32'h0);

    // Clear wins over a coincident event, which is still strobed.
    send_key(1'b1, 1'b0, 8'h29);
    tick(2);
    check("p1_fire_key", {16'h0, ctl_out}, 32'h0010);
    send_key(1'b1, 1'b0, 8'h2B);
    kbd_clear = 1'b1;
    tick(1);
    kbd_clear = 1'b0;
    check("clear_event", {31'h0, key_event}, 32'h1);
    tick(1);
    check("clear_ctl", {16'h0, ctl_out}, 32'h0);
    tick(1);
    check("clear_ctl_hold", {16'h0, ctl_out}, 32'h0);

    send_key(1'b1, 1'b0, 8'h2E);
    watch_coin(0, 25, hi, ri);
    check("coin0_len", hi, 5);
    check("coin0_once", ri, 1);
    send_key(1'b0, 1'b0, 8'h2E);
    tick(2);

    send_key(1'b1, 1'b0, 8'h36);
    watch_coin(1, 15, hi, ri);
    check("coin1_len", hi, 5);
    check("coin1_once", ri, 1);
    send_key(1'b0, 1'b0, 8'h36);
    tick(2);

    // Reset during the second cycle of a pulse drops coin_out immediately.
    send_key(1'b1, 1'b0, 8'h2E);
    tick(2);
    check("coin_mid_c1", {31'h0, coin_out[0]}, 32'h1);
    tick(1);
    check("coin_mid_c2", {31'h0, coin_out[0]}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("coin_reset_drop", {30'h0, coin_out}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_ctl", {15'h0, key_event, ctl_out}, 32'h0);

    joy_in = 32'h0040_0000;
    watch_coin(1, 10, hi, ri);
    check("p2_start_coin1", hi, 5);
    joy_in = 32'h0;
    tick(8);
    joy_in = 32'h0000_0040;
    watch_coin(0, 10, hi, ri);
    check("p1_start_coin0", hi, 5);
    joy_in = 32'h0;
    tick(8);
    joy_in = 32'h0000_0040;
    watch_coin(1, 10, hi_other, ri_other);
    check("p1_start_not_coin1", hi_other, 0);
    joy_in = 32'h0;
    tick(8);

`ifdef ARCADE_AUTOFIRE_EN
    autofire = 2'b01;
`endif
    joy_in = 32'h0010_0010;
    pat = 12'h000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      pat = {pat[10:0], ctl_out[4]};
    end
`ifdef ARCADE_AUTOFIRE_EN
    check("autofire_pattern", {20'h0, pat}, {20'h0, 12'b111000111000});
`else
    check("fire_passthrough", {20'h0, pat}, {20'h0, 12'b111111111111});
`endif
    check("p2_fire_steady", {31'h0, ctl_out[12]}, 32'h1);
    joy_in = 32'h0;
    tick(1);
    check("fire_release", {16'h0, ctl_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
